// File: rtl/serial_frame_rx_pkg.sv
// Shared types and defaults for the serial frame receiver.
// Holds the FSM state enum and default field widths.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    LEN,
    DATA
  } state_t;

  localparam int ADDR_W_DEF = 2;
  localparam int LEN_W_DEF  = 4;

endpackage

// File: rtl/serial_bit_cnt.sv
// Loadable down-counter with zero flag; times each frame field.
// Ports: clk, reset (async low), load/load_val, dec, zero.
module serial_bit_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, address, length, payload.
// Ports: clk, reset, serin, ch_en -> out_data/out_valid, ch_addr, len, busy, done, drop.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  localparam int NUM_CH = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serin,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] out_data,
  output logic [NUM_CH-1:0] out_valid,
  output logic [ADDR_W-1:0] ch_addr,
  output logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              drop
);

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_nx;
  logic [LEN_W-1:0]  len_nx;
  logic              en_lat, en_nx;
  logic [NUM_CH-1:0] od_nx, ov_nx;
  logic              done_nx, drop_nx;

  logic              ld, dec, zero;
  logic [LEN_W-1:0]  ld_val;

  // Counter holds bits remaining minus one in the current field.
  serial_bit_cnt #(
    .W(LEN_W)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (ld),
    .load_val(ld_val),
    .dec     (dec),
    .zero    (zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = ch_addr;
    len_nx   = len;
    en_nx    = en_lat;
    od_nx    = '0;
    ov_nx    = '0;
    done_nx  = 1'b0;
    drop_nx  = 1'b0;
    ld       = 1'b0;
    ld_val   = '0;
    dec      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!serin) begin
          state_nx = ADDR;
          ld       = 1'b1;
          ld_val   = LEN_W'(ADDR_W - 1);
        end
      end
      ADDR: begin
        addr_nx = ADDR_W'({ch_addr, serin});
        dec     = !zero;
        if (zero) begin
          // Enable is frozen here so mid-frame mask edits are ignored.
          en_nx    = ch_en[addr_nx];
          state_nx = LEN;
          ld       = 1'b1;
          ld_val   = LEN_W'(LEN_W - 1);
        end
      end
      LEN: begin
        len_nx = LEN_W'({len, serin});
        dec    = !zero;
        if (zero) begin
          if (len_nx == '0) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            drop_nx  = !en_lat;
          end else begin
            state_nx = DATA;
            ld       = 1'b1;
            ld_val   = len_nx - LEN_W'(1);
          end
        end
      end
      DATA: begin
        dec            = !zero;
        od_nx[ch_addr] = serin;
        ov_nx[ch_addr] = en_lat;
        if (zero) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          drop_nx  = !en_lat;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_addr   <= '0;
      len       <= '0;
      en_lat    <= 1'b0;
      out_data  <= '0;
      out_valid <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      ch_addr   <= addr_nx;
      len       <= len_nx;
      en_lat    <= en_nx;
      out_data  <= od_nx;
      out_valid <= ov_nx;
      busy      <= (state_nx != IDLE);
      done      <= done_nx;
      drop      <= drop_nx;
    end
  end

endmodule
